// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 lines, frame 11-bit words, fold E0/F0 prefixes into key events.
// Optional: define PS2_KBD_RX_PARITY_CHECK_EN to reject frames whose odd-parity bit is wrong.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_p0, clk_s2_p0, dat_s1_p0, dat_s2_p0;
  logic [FW-1:0] filt_cnt;
  logic          fclk, fclk_d, fall;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    sr;
  logic [TW-1:0] to_cnt;
  logic          to_hit, par_ok;
  logic          rdy_d, err_d, clr_d;
  logic          rdy_p1, err_p1, clr_p1;
  logic          ext_flag, rel_flag;

  // Stage p0: two-flop synchronisers, then a run-length filter on the clock line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_p0 <= 1'b1;
      clk_s2_p0 <= 1'b1;
      dat_s1_p0 <= 1'b1;
      dat_s2_p0 <= 1'b1;
      filt_cnt  <= '0;
      fclk      <= 1'b1;
      fclk_d    <= 1'b1;
    end else begin
      clk_s1_p0 <= ps2_clk;
      clk_s2_p0 <= clk_s1_p0;
      dat_s1_p0 <= ps2_data;
      dat_s2_p0 <= dat_s1_p0;
      fclk_d    <= fclk;
      if (clk_s2_p0 == fclk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        fclk     <= clk_s2_p0;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall   = fclk_d & ~fclk;
  assign to_hit = (state_q != S_IDLE) && (to_cnt == TO_LAST);
  assign busy   = (state_q != S_IDLE);

`ifdef PS2_KBD_RX_PARITY_CHECK_EN
  logic par;
  assign par_ok = ^{sr, par};
`else
  assign par_ok = 1'b1;
`endif

  // A falling edge always takes priority over the timeout terminal count
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    clr_d   = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE:   if (!dat_s2_p0) state_d = S_DATA;
                  else            err_d   = 1'b1;
        S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_p0 && par_ok) begin
            rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
            clr_d = 1'b1;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end else if (to_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      clr_d   = 1'b1;
    end
  end

  // Stage p1: frame state, timeout counter and byte/error strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
      rdy_p1  <= 1'b0;
      err_p1  <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_p1  <= rdy_d;
      err_p1  <= err_d;
      clr_p1  <= clr_d;
      if (fall && state_q == S_IDLE) bit_cnt <= '0;
      else if (fall && state_q == S_DATA) bit_cnt <= bit_cnt + 1'b1;
      if (state_q == S_IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
    end
  end

  // Shift register is pure data; it is fully rewritten by every accepted frame
  always_ff @(posedge clk) begin
    if (fall && state_q == S_DATA) sr <= {dat_s2_p0, sr[7:1]};
`ifdef PS2_KBD_RX_PARITY_CHECK_EN
    if (fall && state_q == S_PARITY) par <= dat_s2_p0;
`endif
  end

  // Stage p2: prefix folding and key event registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= err_p1;
      if (rdy_p1) begin
        case (sr)
          8'hE0: ext_flag <= 1'b1;
          8'hF0: rel_flag <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
          default: begin
            key_code    <= sr;
            key_ext     <= ext_flag;
            key_release <= rel_flag;
            key_valid   <= 1'b1;
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
          end
        endcase
      end else if (err_p1 && clr_p1) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end
    end
  end
endmodule
